// File: rtl/store_buffer.sv
// In-order store buffer between the MEM stage and a single-ported data SRAM.
// Stores are lane-formed on entry and drain one per cycle when loads leave the port free.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     st_valid,
    output logic                     st_ready,
    input  logic [AW-1:0]            st_addr,
    input  logic [31:0]              st_wdata,
    input  logic [2:0]               st_mode,
    input  logic                     ld_req,
    input  logic [AW-1:0]            ld_addr,
    output logic                     ld_conflict,
    output logic                     sram_en,
    output logic [3:0]               sram_we,
    output logic [AW-1:0]            sram_addr,
    output logic [31:0]              sram_wdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);

    // Handshake: a store transfers on any rising edge where st_valid && st_ready;
    // st_ready depends only on occupancy, never on st_valid, and the buffer
    // offers no bypass while full.

    logic [AW-3:0]    waddr_q [DEPTH];
    logic [3:0]       we_q    [DEPTH];
    logic [31:0]      data_q  [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [PW:0]      count_q, count_d;

    logic             enq;
    logic             drain;
    logic [3:0]       new_we;
    logic [31:0]      new_data;
    logic [DEPTH-1:0] hit;
    logic             unused_ld_lo;

    assign unused_ld_lo = ^ld_addr[1:0];

    always_comb begin
        new_we   = 4'b0000;
        new_data = st_wdata;
        case (st_mode)
            3'b001: begin
                new_we   = 4'b0001 << st_addr[1:0];
                new_data = {4{st_wdata[7:0]}};
            end
            3'b010: begin
                new_we   = st_addr[1] ? 4'b1100 : 4'b0011;
                new_data = {2{st_wdata[15:0]}};
            end
            3'b100: begin
                new_we   = 4'b1111;
                new_data = st_wdata;
            end
            // Malformed size: keep the slot so ordering holds, but write nothing.
            default: begin
                new_we   = 4'b0000;
                new_data = st_wdata;
            end
        endcase
    end

    always_comb begin
        hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hit[i] = valid_q[i] && (waddr_q[i] == ld_addr[AW-1:2]);
        end
    end

    assign ld_conflict = ld_req && (|hit);
    assign st_ready    = (count_q != (PW+1)'(DEPTH));
    assign enq         = st_valid && st_ready;
    // A conflicting load is refused the port, so the matching store can always drain.
    assign drain       = (count_q != '0) && (!ld_req || ld_conflict);

    assign sram_en    = drain;
    assign sram_we    = drain ? we_q[head_q] : 4'b0000;
    assign sram_addr  = {waddr_q[head_q], 2'b00};
    assign sram_wdata = data_q[head_q];
    assign count      = count_q;
    assign empty      = (count_q == '0);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q + (PW+1)'(enq) - (PW+1)'(drain);
        if (drain) begin
            head_d = head_q + PW'(1);
        end
        if (enq) begin
            tail_d = tail_q + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                waddr_q[i] <= '0;
                we_q[i]    <= '0;
                data_q[i]  <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (drain) begin
                valid_q[head_q] <= 1'b0;
            end
            if (enq) begin
                valid_q[tail_q] <= 1'b1;
                waddr_q[tail_q] <= st_addr[AW-1:2];
                we_q[tail_q]    <= new_we;
                data_q[tail_q]  <= new_data;
            end
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed scenarios with literal expectations plus
// random traffic compared every cycle against a queue-based model.
module tb_store_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int EW    = 67;   // {word addr[29:0], we[3:0], data[31:0], data_dont_care}

    logic          clk = 1'b0;
    logic          reset;
    logic          st_valid;
    logic          st_ready;
    logic [AW-1:0] st_addr;
    logic [31:0]   st_wdata;
    logic [2:0]    st_mode;
    logic          ld_req;
    logic [AW-1:0] ld_addr;
    logic          ld_conflict;
    logic          sram_en;
    logic [3:0]    sram_we;
    logic [AW-1:0] sram_addr;
    logic [31:0]   sram_wdata;
    logic [2:0]    count;
    logic          empty;

    int n_tests = 0;
    int n_fail  = 0;
    logic [EW-1:0] exp_q[$];

    store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
        .st_wdata(st_wdata), .st_mode(st_mode),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_conflict(ld_conflict),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .count(count), .empty(empty)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [EW-1:0] form(input logic [31:0] a, input logic [31:0] d,
                                           input logic [2:0] m);
        logic [3:0]  we;
        logic [31:0] wd;
        logic        dc;
        we = 4'b0000; wd = d; dc = 1'b0;
        if (m == 3'b001) begin
            we = 4'(1 << a[1:0]);
            wd = {d[7:0], d[7:0], d[7:0], d[7:0]};
        end else if (m == 3'b010) begin
            we = a[1] ? 4'b1100 : 4'b0011;
            wd = {d[15:0], d[15:0]};
        end else if (m == 3'b100) begin
            we = 4'b1111;
        end else begin
            dc = 1'b1;
        end
        return {a[31:2], we, wd, dc};
    endfunction

    function automatic logic model_hit(input logic [31:0] la);
        logic h;
        h = 1'b0;
        foreach (exp_q[i]) begin
            if (exp_q[i][66:37] == la[31:2]) h = 1'b1;
        end
        return h;
    endfunction

    // ---------------- model update ----------------
    always @(posedge clk or posedge reset) begin : model
        logic conf, drn, rdy;
        if (reset) begin
            exp_q.delete();
        end else begin
            conf = ld_req && model_hit(ld_addr);
            drn  = (exp_q.size() > 0) && (!ld_req || conf);
            rdy  = (exp_q.size() != DEPTH);
            if (drn) void'(exp_q.pop_front());
            if (st_valid && rdy) exp_q.push_back(form(st_addr, st_wdata, st_mode));
        end
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin : cmp
        logic conf, drn;
        logic [EW-1:0] h;
        conf = ld_req && model_hit(ld_addr);
        drn  = (exp_q.size() > 0) && (!ld_req || conf);
        chk("count", 64'(count), 64'(exp_q.size()));
        chk("empty", 64'(empty), 64'(exp_q.size() == 0));
        chk("st_ready", 64'(st_ready), 64'(exp_q.size() != DEPTH));
        chk("ld_conflict", 64'(ld_conflict), 64'(conf));
        chk("sram_en", 64'(sram_en), 64'(drn));
        if (exp_q.size() > 0) begin
            h = exp_q[0];
            chk("sram_we", 64'(sram_we), drn ? 64'(h[36:33]) : 64'(0));
            chk("sram_addr", 64'(sram_addr), 64'({h[66:37], 2'b00}));
            if (!h[0]) chk("sram_wdata", 64'(sram_wdata), 64'(h[32:1]));
        end else begin
            chk("sram_we_idle", 64'(sram_we), 64'(0));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] m, input logic lr, input logic [31:0] la);
        @(posedge clk);
        #1;
        st_valid = v; st_addr = a; st_wdata = d; st_mode = m;
        ld_req = lr; ld_addr = la;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 32'h0, 3'b000, 1'b0, 32'h0);
    endtask

    task automatic single(input logic [31:0] a, input logic [31:0] d, input logic [2:0] m,
                          input logic [3:0] we, input logic [31:0] wd, input string nm);
        drive(1'b1, a, d, m, 1'b0, 32'h0);
        idle();
        @(negedge clk);
        chk({nm, "_en"}, 64'(sram_en), 64'(1));
        chk({nm, "_we"}, 64'(sram_we), 64'(we));
        chk({nm, "_wdata"}, 64'(sram_wdata), 64'(wd));
        idle();
        @(negedge clk);
        chk({nm, "_empty"}, 64'(empty), 64'(1));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        st_valid = 1'b0; st_addr = '0; st_wdata = '0; st_mode = '0;
        ld_req = 1'b0; ld_addr = '0;
        #3;
        chk("rst_ready", 64'(st_ready), 64'(1));
        chk("rst_empty", 64'(empty), 64'(1));
        chk("rst_count", 64'(count), 64'(0));
        chk("rst_en", 64'(sram_en), 64'(0));
        chk("rst_we", 64'(sram_we), 64'(0));
        chk("rst_addr", 64'(sram_addr), 64'(0));
        chk("rst_wdata", 64'(sram_wdata), 64'(0));
        #9 reset = 1'b0;

        // single word store
        drive(1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 3'b100, 1'b0, 32'h0);
        idle();
        @(negedge clk);
        chk("word_en", 64'(sram_en), 64'(1));
        chk("word_addr", 64'(sram_addr), 64'h1004);
        chk("word_we", 64'(sram_we), 64'hF);
        chk("word_wdata", 64'(sram_wdata), 64'hDEAD_BEEF);
        idle();
        @(negedge clk);
        chk("word_empty", 64'(empty), 64'(1));

        // lane forming
        single(32'h2003, 32'h0000_00AB, 3'b001, 4'b1000, 32'hABAB_ABAB, "byte3");
        single(32'h2002, 32'h0000_1234, 3'b010, 4'b1100, 32'h1234_1234, "half2");
        single(32'h2001, 32'h0000_5678, 3'b010, 4'b0011, 32'h5678_5678, "half1");

        // full with load priority
        for (int k = 0; k < 4; k++)
            drive(1'b1, 32'h4000 + 32'(4*k), 32'h100 + 32'(k), 3'b100, 1'b1, 32'h9000);
        drive(1'b0, 32'h0, 32'h0, 3'b000, 1'b1, 32'h9000);
        @(negedge clk);
        chk("full_count", 64'(count), 64'(4));
        chk("full_ready", 64'(st_ready), 64'(0));
        chk("full_en", 64'(sram_en), 64'(0));
        for (int k = 0; k < 4; k++) begin
            idle();
            @(negedge clk);
            chk("full_drain_en", 64'(sram_en), 64'(1));
            chk("full_drain_addr", 64'(sram_addr), 64'(32'h4000 + 32'(4*k)));
            chk("full_drain_count", 64'(count), 64'(4 - k));
            chk("full_drain_ready", 64'(st_ready), 64'(k > 0));
        end
        idle();
        @(negedge clk);
        chk("full_final_count", 64'(count), 64'(0));

        // load conflict
        drive(1'b1, 32'h3000, 32'h11, 3'b100, 1'b1, 32'h3012);
        drive(1'b1, 32'h3010, 32'h22, 3'b100, 1'b1, 32'h3012);
        drive(1'b0, 32'h0, 32'h0, 3'b000, 1'b1, 32'h3012);
        @(negedge clk);
        chk("conf_a", 64'(ld_conflict), 64'(1));
        chk("conf_a_addr", 64'(sram_addr), 64'h3000);
        chk("conf_a_en", 64'(sram_en), 64'(1));
        drive(1'b0, 32'h0, 32'h0, 3'b000, 1'b1, 32'h3012);
        @(negedge clk);
        chk("conf_b", 64'(ld_conflict), 64'(1));
        chk("conf_b_addr", 64'(sram_addr), 64'h3010);
        drive(1'b0, 32'h0, 32'h0, 3'b000, 1'b1, 32'h3012);
        @(negedge clk);
        chk("conf_fall", 64'(ld_conflict), 64'(0));
        chk("conf_empty", 64'(empty), 64'(1));

        // concurrent enqueue and drain
        drive(1'b1, 32'h5000, 32'h1, 3'b100, 1'b1, 32'h9000);
        drive(1'b1, 32'h5004, 32'h2, 3'b100, 1'b1, 32'h9000);
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'h5008 + 32'(4*k), 32'h3 + 32'(k), 3'b100, 1'b0, 32'h0);
            @(negedge clk);
            chk("conc_count", 64'(count), 64'(2));
        end
        for (int k = 0; k < 3; k++) begin
            idle();
            @(negedge clk);
            chk("conc_drain_count", 64'(count), 64'(2 - k));
        end

        // async reset mid-drain
        for (int k = 0; k < 3; k++)
            drive(1'b1, 32'h7000 + 32'(4*k), 32'hA0 + 32'(k), 3'b100, 1'b1, 32'h9000);
        @(posedge clk);
        #1;
        st_valid = 1'b0; ld_req = 1'b0;
        #1;
        chk("pre_rst_en", 64'(sram_en), 64'(1));
        chk("pre_rst_count", 64'(count), 64'(3));
        #1 reset = 1'b1;
        #1;
        chk("arst_en", 64'(sram_en), 64'(0));
        chk("arst_count", 64'(count), 64'(0));
        chk("arst_empty", 64'(empty), 64'(1));
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idle();
            @(negedge clk);
            chk("post_rst_en", 64'(sram_en), 64'(0));
        end

        // random traffic
        for (int n = 0; n < 400; n++) begin
            logic [31:0] a, la;
            logic [2:0]  m;
            int          sel;
            a   = 32'h6000 + 32'(4 * $urandom_range(0, 3)) + 32'($urandom_range(0, 3));
            la  = 32'h6000 + 32'(4 * $urandom_range(0, 4)) + 32'($urandom_range(0, 3));
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1, 2: m = 3'b001;
                3, 4, 5: m = 3'b010;
                6, 7:    m = 3'b100;
                8:       m = 3'b011;
                default: m = 3'b000;
            endcase
            drive(1'($urandom_range(0, 1)), a, $urandom, m,
                  ($urandom_range(0, 9) < 4), la);
        end
        for (int k = 0; k < 6; k++) idle();
        @(negedge clk);
        chk("final_empty", 64'(empty), 64'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Small in-order FIFO that decouples CPU store instructions from the single-ported data SRAM.
- Stores from the MEM stage are queued with their byte-lane write enables and lane-aligned write data already formed.
- The queue drains one entry per cycle whenever the load path does not need the SRAM port.
- Sits between the MEM stage and the data SRAM. It also flags loads that hit a pending store so the pipeline can stall them until the store drains.

Parameters:
- DEPTH, 4: number of buffered stores; power of two, minimum 2.
- AW, 32: address width in bits.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- st_valid  input  1  MEM stage presents a store.
- st_ready  output  1  buffer can accept a store this cycle.
- st_addr  input  AW  byte address of the store.
- st_wdata  input  32  store data, right-justified (byte in [7:0], half in [15:0]).
- st_mode  input  3  one-hot size: bit2 = word, bit1 = half, bit0 = byte.
- ld_req  input  1  load wants the SRAM port this cycle.
- ld_addr  input  AW  byte address of that load.
- ld_conflict  output  1  load word address matches a buffered store.
- sram_en  output  1  SRAM access strobe for a buffered write.
- sram_we  output  4  byte-lane write enables.
- sram_addr  output  AW  word-aligned address; bits [1:0] are always 0.
- sram_wdata  output  32  lane-aligned write data.
- count  output  log2(DEPTH)+1  number of occupied entries.
- empty  output  1  count == 0.

Behaviour:
- **Reset** (asynchronous, any cycle, including mid-drain): head, tail and count go to 0 and all entries are discarded. Outputs then read: st_ready = 1, empty = 1, sram_en = 0, sram_we = 0, sram_addr = 0, sram_wdata = 0, ld_conflict = 0.
- **Enqueue** occurs when st_valid && st_ready. st_ready = (count != DEPTH); there is no same-cycle bypass while full.
- **Lane formation** happens at enqueue. Let lo = st_addr[1:0].
  - Byte: we = one-hot at lane lo; data = st_wdata[7:0] replicated into all four lanes.
  - Half: lo[1] = 0 gives we = 0011; lo[1] = 1 gives we = 1100. lo[0] is ignored (no misalign trap here). Data = st_wdata[15:0] in both halves.
  - Word: we = 1111; data = st_wdata. lo is ignored.
  - Non-one-hot st_mode: entry is stored with we = 0000 and drains as a harmless no-op write.
- **Stored fields**: each entry holds the word address (st_addr[AW-1:2]), the 4-bit we and 32-bit data.
- **Drain condition**: count > 0 && (!ld_req || ld_conflict). A conflicting load is not granted the port, so the store drains and no deadlock can occur.
- **Drain outputs**: while draining, sram_en = 1 and sram_we, sram_addr and sram_wdata come combinationally from the head entry. The head is popped at the clock edge.
- **Idle outputs**: when not draining, sram_en = 0 and sram_we = 0. sram_addr and sram_wdata are don't-care but must be driven from the head.
- **Latency**: a store accepted in cycle N reaches the SRAM no earlier than cycle N+1.
- **Simultaneous enqueue and drain**: count is unchanged, with head and tail both advancing. This is legal when full: the drain frees a slot, but st_ready was already 0 that cycle, so no enqueue occurs.
- **Pointer wrap**: head and tail wrap modulo DEPTH.
- **ld_conflict** is combinational: ld_req && any valid entry whose word address equals ld_addr[AW-1:2].
  - It is deasserted once the last matching entry drains.
  - A store being enqueued in the same cycle is not compared; the MEM stage ordering guarantees it.
- **Ordering**: entries drain strictly in FIFO order. Multiple stores to the same word are preserved in order and are never merged.

Test Plan:
- **Single word store**: reset, then st_valid with st_addr = 0x0000_1004, st_mode = 100, st_wdata = 0xDEADBEEF, ld_req = 0. Next cycle expect sram_en = 1, sram_addr = 0x0000_1004, sram_we = 1111, sram_wdata = 0xDEADBEEF. The cycle after, expect empty = 1.
- **Lane forming**:
  - Byte store to 0x2003 with data 0x000000AB gives sram_we = 1000 and sram_wdata = 0xABABABAB.
  - Half store to 0x2002 with data 0x00001234 gives sram_we = 1100 and sram_wdata = 0x12341234.
  - Half store to 0x2001 gives sram_we = 0011.
- **Full and load priority**: hold ld_req = 1 with non-matching ld_addr and enqueue 4 stores. Expect count = 4 and st_ready = 0 with no SRAM writes. Drop ld_req: expect the 4 writes on consecutive cycles in FIFO order, count 3, 2, 1, 0, and st_ready = 1 after the first drain.
- **Conflict**: buffer stores to 0x3000 and 0x3010 with ld_req = 1 and ld_addr = 0x3012. Expect ld_conflict = 1 and the buffer drains anyway. ld_conflict must fall exactly in the cycle after the 0x3010 entry drains.
- **Concurrent enqueue and drain**: with count = 2 and ld_req = 0, present st_valid for 3 cycles. Expect count to stay at 2 until input stops, then drain to 0, with data order matching issue order.
- **Async reset mid-drain**: with count = 3, assert reset between clock edges. Expect sram_en = 0, count = 0 and empty = 1 immediately with no clock. After release, no stale writes appear.
